// File: rtl/wb_pkg.sv
// Writeback arbitration package.
// Shared types and constants for the regfile writeback arbiter:
//   NUM_WB_REQ - number of writeback sources feeding the regfile write port
//   WB_ALU/WB_LD/WB_MDU - requester indices, oldest pipeline stage first
//   wb_req_t   - destination register plus write data of one writeback
package wb_pkg;

   localparam int unsigned NUM_WB_REQ = 3;

   localparam int unsigned WB_ALU = 0;
   localparam int unsigned WB_LD  = 1;
   localparam int unsigned WB_MDU = 2;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker (pure combinational).
// Grants the first asserted request found when searching upward from ptr,
// wrapping past N-1 to 0.
//   req   in  N   request vector
//   ptr   in  PW  index where the search starts (must be < N)
//   grant out N   one-hot grant, or zero when no request is asserted
module rr_arbiter #(
   parameter int unsigned N  = 3,
   parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant
);

   logic found;

   // Two passes: indices at/after ptr first, then the wrapped-around ones.
   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!found && req[i] && (i >= 32'(ptr))) begin
            grant[i] = 1'b1;
            found    = 1'b1;
         end
      end
      for (int unsigned i = 0; i < N; i++) begin
         if (!found && req[i] && (i < 32'(ptr))) begin
            grant[i] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Regfile writeback arbiter.
// Shares the single regfile write port among NUM_REQ writeback sources using
// round-robin arbitration, with an override that keeps writes to the same
// destination register in age order. The grant is registered into an output
// stage that drives the regfile one cycle later.
//   clk, rst      clock; synchronous active-high reset
//   req_valid     per-requester writeback pending
//   req_rd        per-requester destination register
//   req_data      per-requester write data
//   req_ready     per-requester grant (combinational, one-hot or zero)
//   regf_we       regfile write enable
//   rd_s, rd_v    regfile write index / data
//   pending_mask  registers targeted by a valid request or the output stage
//   conflict_cnt  saturating count of cycles with more than one request
module regfile_wb_arbiter
   import wb_pkg::*;
#(
   parameter int unsigned NUM_REQ = NUM_WB_REQ,
   parameter int unsigned CNT_W   = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0][4:0]   req_rd,
   input  logic [NUM_REQ-1:0][31:0]  req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      regf_we,
   output logic [4:0]                rd_s,
   output logic [31:0]               rd_v,
   output logic [31:0]               pending_mask,
   output logic [CNT_W-1:0]          conflict_cnt
);

   localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PW-1:0]      ptr_q;
   logic [PW-1:0]      ptr_next;
   logic [NUM_REQ-1:0] rr_grant;
   logic [NUM_REQ-1:0] grant;
   logic               any_grant;
   logic               win_found;
   int unsigned        win_pos;
   logic [4:0]         win_rd;
   logic               ovr;
   wb_req_t            gnt_req;
   logic               we_q;

   rr_arbiter #(
      .N  (NUM_REQ),
      .PW (PW)
   ) u_rr (
      .req   (req_valid),
      .ptr   (ptr_q),
      .grant (rr_grant)
   );

   // Ordering override: an older requester writing the same non-zero rd as
   // the round-robin winner must go first, otherwise the regfile would end
   // up holding the older value.
   always_comb begin
      win_found = 1'b0;
      win_pos   = 0;
      win_rd    = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (rr_grant[i]) begin
            win_found = 1'b1;
            win_pos   = i;
            win_rd    = req_rd[i];
         end
      end

      grant = rr_grant;
      ovr   = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!ovr && win_found && (i < win_pos) && req_valid[i] &&
             (req_rd[i] == win_rd) && (win_rd != '0)) begin
            grant    = '0;
            grant[i] = 1'b1;
            ovr      = 1'b1;
         end
      end
      if (rst) begin
         grant = '0;
      end
   end

   always_comb begin
      any_grant = |grant;
      ptr_next  = ptr_q;
      gnt_req   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            ptr_next     = (i == NUM_REQ - 1) ? '0 : PW'(i + 1);
            gnt_req.rd   = req_rd[i];
            gnt_req.data = req_data[i];
         end
      end
   end

   assign req_ready = grant;

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q         <= 1'b0;
         rd_s         <= '0;
         rd_v         <= '0;
         ptr_q        <= '0;
         conflict_cnt <= '0;
      end else begin
         // rd==0 writebacks are consumed but never written.
         we_q <= any_grant && (gnt_req.rd != '0);
         if (any_grant) begin
            rd_s  <= gnt_req.rd;
            rd_v  <= gnt_req.data;
            ptr_q <= ptr_next;
         end
         if (($countones(req_valid) > 1) && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
         end
      end
   end

   // Gating with rst drops a write already registered when reset arrives.
   assign regf_we = we_q && !rst;

   always_comb begin
      pending_mask = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (req_valid[i]) begin
            pending_mask[req_rd[i]] = 1'b1;
         end
      end
      if (regf_we) begin
         pending_mask[rd_s] = 1'b1;
      end
      pending_mask[0] = 1'b0;
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_hold_chk
      hold_stable: assert property (@(posedge clk) disable iff (rst)
         (req_valid[g] && !req_ready[g]) |=>
            (!req_valid[g] || ($stable(req_rd[g]) && $stable(req_data[g]))));
   end

endmodule
